// File: rtl/pipe_ctrl_pkg.sv
// pipe_ctrl_pkg: shared types, constants and helpers for the pipeline stall/flush sequencer
package pipe_ctrl_pkg;
   typedef logic [4:0] reg_idx_t;
   typedef enum logic [1:0] {RUN, MEM_WAIT, MEM_ERR} state_e;
   localparam reg_idx_t REG_ZERO = 5'd0;
   // Control-bundle bit positions, shared with the pipeline registers
   localparam int CTL_REGWRITE = 0;
   localparam int CTL_MEMREAD  = 1;
   localparam int CTL_MEMWRITE = 2;
   localparam int CTL_BRANCH   = 3;
   localparam int CTL_MEMTOREG = 4;
   localparam int CTL_W        = 5;
   function automatic logic reg_hit(input reg_idx_t wr, input reg_idx_t rd);
      return (wr != REG_ZERO) && (wr == rd);
   endfunction
endpackage

// File: rtl/load_use_detect.sv
// load_use_detect: flags a load in EX whose destination feeds a source of the instruction in ID
module load_use_detect
   import pipe_ctrl_pkg::*;
(
   input  logic [4:0] ID_rs,
   input  logic [4:0] ID_rt,
   input  logic       EX_memread,
   input  logic [4:0] EX_writereg,
   output logic       hazard
);
   assign hazard = EX_memread & (reg_hit(EX_writereg, ID_rs) | reg_hit(EX_writereg, ID_rt));
endmodule

// File: rtl/pipeline_ctrl.sv
// pipeline_ctrl: per-cycle advance/hold/flush decisions for the five-stage pipeline,
// covering load-use hazards, taken branches and handshaked data-memory waits
module pipeline_ctrl
   import pipe_ctrl_pkg::*;
#(
   parameter int MEM_TIMEOUT = 64,
   parameter int CNT_W       = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [4:0]       ID_rs,
   input  logic [4:0]       ID_rt,
   input  logic             EX_memread,
   input  logic [4:0]       EX_writereg,
   input  logic             EX_branch_taken,
   input  logic             MEM_memread,
   input  logic             MEM_memwrite,
   input  logic             dmem_ready,
   output logic             dmem_req,
   output logic             pc_en,
   output logic             IF_ID_en,
   output logic             ID_EX_en,
   output logic             EX_MEM_en,
   output logic             MEM_WB_en,
   output logic             IF_ID_flush,
   output logic             ID_EX_flush,
   output logic             MEM_WB_bubble,
   output logic [CNT_W-1:0] stall_cycles,
   output logic             mem_err
);
   localparam int WC_W = $clog2(MEM_TIMEOUT + 1);
   state_e            state_q, state_d;
   logic [WC_W-1:0]   wait_cnt_q, wait_cnt_d;
   logic [CNT_W-1:0]  stall_q, stall_d;
   logic              mem_err_q, mem_err_d;
   logic              hazard, mem_op, in_run, in_wait, in_err, mem_stall, lu_stall, flow;
   load_use_detect u_lud (
      .ID_rs       (ID_rs),
      .ID_rt       (ID_rt),
      .EX_memread  (EX_memread),
      .EX_writereg (EX_writereg),
      .hazard      (hazard)
   );
   assign mem_op    = MEM_memread | MEM_memwrite;
   assign in_run    = state_q == RUN;
   assign in_wait   = state_q == MEM_WAIT;
   assign in_err    = state_q == MEM_ERR;
   assign mem_stall = ((in_run & mem_op) | in_wait) & ~dmem_ready;
   assign flow      = ~in_err & ~mem_stall;
   // A taken branch squashes the dependent instruction, so it overrides load-use
   assign lu_stall  = flow & ~EX_branch_taken & hazard;
   always_comb begin
      dmem_req      = rst_n & ((in_run & mem_op) | in_wait);
      pc_en         = rst_n & flow & ~lu_stall;
      IF_ID_en      = rst_n & flow & ~lu_stall;
      ID_EX_en      = rst_n & flow;
      EX_MEM_en     = rst_n & flow;
      MEM_WB_en     = rst_n & ~in_err;
      IF_ID_flush   = rst_n & flow & EX_branch_taken;
      ID_EX_flush   = rst_n & flow & (EX_branch_taken | hazard);
      MEM_WB_bubble = rst_n & mem_stall;
      stall_cycles  = stall_q;
      mem_err       = mem_err_q;
   end
   always_comb begin
      state_d    = state_q;
      wait_cnt_d = wait_cnt_q;
      mem_err_d  = mem_err_q;
      stall_d    = ((mem_stall | lu_stall) & ~&stall_q) ? stall_q + 1'b1 : stall_q;
      case (state_q)
         RUN: if (mem_op & ~dmem_ready) begin
            state_d    = MEM_WAIT;
            wait_cnt_d = WC_W'(1);
         end
         MEM_WAIT: if (dmem_ready) begin
            state_d    = RUN;
            wait_cnt_d = '0;
         end else if (wait_cnt_q == WC_W'(MEM_TIMEOUT)) begin
            state_d   = MEM_ERR;
            mem_err_d = 1'b1;
         end else begin
            wait_cnt_d = wait_cnt_q + 1'b1;
         end
         default: ;
      endcase
   end
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= RUN;
         wait_cnt_q <= '0;
         stall_q    <= '0;
         mem_err_q  <= 1'b0;
      end else begin
         state_q    <= state_d;
         wait_cnt_q <= wait_cnt_d;
         stall_q    <= stall_d;
         mem_err_q  <= mem_err_d;
      end
   end
endmodule

// File: tb/tb_pipeline_ctrl.sv
// tb_pipeline_ctrl: directed and randomized checks of pipeline_ctrl against a behavioural model
module tb_pipeline_ctrl;
   localparam int T = 4;
   localparam int CW = 4;
   logic clk = 1'b0;
   logic rst_n;
   logic [4:0] ID_rs, ID_rt, EX_writereg;
   logic EX_memread, EX_branch_taken, MEM_memread, MEM_memwrite, dmem_ready;
   logic dmem_req, pc_en, IF_ID_en, ID_EX_en, EX_MEM_en, MEM_WB_en;
   logic IF_ID_flush, ID_EX_flush, MEM_WB_bubble, mem_err;
   logic [CW-1:0] stall_cycles;
   int checks = 0;
   int errors = 0;
   bit m_wait, m_err;
   int m_waited, m_stall;
   always #5 clk = ~clk;
   pipeline_ctrl #(.MEM_TIMEOUT(T), .CNT_W(CW)) dut (
      .clk(clk), .rst_n(rst_n), .ID_rs(ID_rs), .ID_rt(ID_rt), .EX_memread(EX_memread),
      .EX_writereg(EX_writereg), .EX_branch_taken(EX_branch_taken), .MEM_memread(MEM_memread),
      .MEM_memwrite(MEM_memwrite), .dmem_ready(dmem_ready), .dmem_req(dmem_req), .pc_en(pc_en),
      .IF_ID_en(IF_ID_en), .ID_EX_en(ID_EX_en), .EX_MEM_en(EX_MEM_en), .MEM_WB_en(MEM_WB_en),
      .IF_ID_flush(IF_ID_flush), .ID_EX_flush(ID_EX_flush), .MEM_WB_bubble(MEM_WB_bubble),
      .stall_cycles(stall_cycles), .mem_err(mem_err)
   );
   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %0h expected %0h", tag, got, exp);
      end
   endtask
   function automatic bit m_hazard();
      return EX_memread && EX_writereg != 0 && (EX_writereg == ID_rs || EX_writereg == ID_rt);
   endfunction
   function automatic bit m_memwait();
      return (m_wait || MEM_memread || MEM_memwrite) && !dmem_ready;
   endfunction
   // {pc, if_id, id_ex, ex_mem, mem_wb, if_flush, id_flush, bubble, req}
   function automatic logic [8:0] m_out();
      bit req = m_wait || MEM_memread || MEM_memwrite;
      if (!rst_n || m_err) return 9'b0;
      if (m_memwait()) return 9'b00001_00_1_1;
      if (EX_branch_taken) return {7'b11111_11, 1'b0, req};
      if (m_hazard()) return {7'b00111_01, 1'b0, req};
      return {7'b11111_00, 1'b0, req};
   endfunction
   task automatic m_advance();
      if (!rst_n || m_err) return;
      if (m_memwait() || (!EX_branch_taken && m_hazard())) m_stall = (m_stall + 1 > 15) ? 15 : m_stall + 1;
      if (m_wait) begin
         if (dmem_ready) m_wait = 0;
         else if (m_waited == T) m_err = 1;
         else m_waited++;
      end else if ((MEM_memread || MEM_memwrite) && !dmem_ready) begin
         m_wait = 1;
         m_waited = 1;
      end
   endtask
   task automatic step(input string tag);
      #1;
      chk({tag, ".ctl"}, 32'({pc_en, IF_ID_en, ID_EX_en, EX_MEM_en, MEM_WB_en, IF_ID_flush,
                             ID_EX_flush, MEM_WB_bubble, dmem_req}), 32'(m_out()));
      chk({tag, ".cnt"}, 32'(stall_cycles), 32'(m_stall));
      chk({tag, ".err"}, 32'(mem_err), 32'(m_err));
      m_advance();
      @(posedge clk);
      #2;
   endtask
   task automatic drop_rst();
      rst_n = 1'b0;
      m_wait = 0; m_err = 0; m_waited = 0; m_stall = 0;
   endtask
   task automatic idle();
      ID_rs = 0; ID_rt = 0; EX_writereg = 0; EX_memread = 0; EX_branch_taken = 0;
      MEM_memread = 0; MEM_memwrite = 0; dmem_ready = 0;
   endtask
   task automatic do_reset();
      drop_rst();
      step("rst");
      rst_n = 1'b1;
   endtask
   initial begin
      idle();
      drop_rst();
      repeat (2) @(posedge clk);
      #2;
      step("reset");
      rst_n = 1'b1;
      step("idle");
      EX_memread = 1; EX_writereg = 5; ID_rs = 5; ID_rt = 9;
      step("lu");
      chk("lu_cnt", 32'(stall_cycles), 32'd1);
      EX_memread = 0;
      step("lu_clear");
      EX_memread = 1; EX_writereg = 0; ID_rs = 0; ID_rt = 0;
      step("lu_zero");
      chk("lu_zero_cnt", 32'(stall_cycles), 32'd1);
      EX_writereg = 7; ID_rt = 7; EX_branch_taken = 1;
      step("br_lu");
      chk("br_lu_cnt", 32'(stall_cycles), 32'd1);
      idle();
      do_reset();
      MEM_memread = 1;
      for (int i = 0; i < 3; i++) step("slow_wait");
      dmem_ready = 1;
      step("slow_rel");
      chk("slow_cnt", 32'(stall_cycles), 32'd3);
      idle();
      step("slow_after");
      MEM_memwrite = 1; dmem_ready = 1;
      step("fast_mem");
      chk("fast_cnt", 32'(stall_cycles), 32'd3);
      idle();
      do_reset();
      MEM_memread = 1;
      for (int i = 0; i < T + 1; i++) step("to_wait");
      chk("to_err", 32'(mem_err), 32'd1);
      dmem_ready = 1;
      step("to_late");
      chk("to_sticky", 32'(mem_err), 32'd1);
      idle();
      do_reset();
      step("to_cleared");
      EX_memread = 1; EX_writereg = 3; ID_rs = 3;
      for (int i = 0; i < 20; i++) step("sat");
      chk("sat_cnt", 32'(stall_cycles), 32'd15);
      idle();
      do_reset();
      MEM_memwrite = 1;
      step("ar_run");
      step("ar_wait");
      drop_rst();
      #1;
      chk("ar_async", 32'({pc_en, IF_ID_en, ID_EX_en, EX_MEM_en, MEM_WB_en, IF_ID_flush, ID_EX_flush,
                           MEM_WB_bubble, dmem_req, mem_err, stall_cycles}), 32'd0);
      step("ar_held");
      rst_n = 1'b1;
      MEM_memwrite = 0;
      step("ar_run_again");
      for (int n = 0; n < 800; n++) begin
         if (($urandom_range(0, 99) < 3) || (m_err && $urandom_range(0, 3) == 0)) begin
            drop_rst();
            step("rnd_rst");
            rst_n = 1'b1;
         end
         ID_rs = 5'($urandom_range(0, 3));
         ID_rt = 5'($urandom_range(0, 3));
         EX_writereg = 5'($urandom_range(0, 3));
         EX_memread = ($urandom_range(0, 1) == 1);
         EX_branch_taken = ($urandom_range(0, 99) < 15);
         MEM_memread = ($urandom_range(0, 99) < 20);
         MEM_memwrite = ($urandom_range(0, 99) < 15);
         dmem_ready = ($urandom_range(0, 99) < 60);
         step("rnd");
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/pipeline_ctrl.md
# pipeline_ctrl

Central stall/flush sequencer for the five-stage pipeline. Every cycle it decides which pipeline registers (PC, IF/ID, ID/EX, EX/MEM, MEM/WB) advance, hold or are flushed. It covers three causes: load-use hazards, taken branches, and multi-cycle data-memory accesses through a req/ready handshake. It also keeps a stall counter and raises a sticky error on a memory timeout.

## Interface
Parameters:
- MEM_TIMEOUT, 64: maximum cycles spent in MEM_WAIT before error (≥2).
- CNT_W, 16: width of stall_cycles.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous, active-low reset.
- ID_rs, ID_rt  in  5 each  source registers of the instruction in ID.
- EX_memread  in  1  instruction in EX is a load.
- EX_writereg  in  5  destination register of the instruction in EX.
- EX_branch_taken  in  1  branch in EX resolved taken.
- MEM_memread, MEM_memwrite  in  1 each  instruction in MEM accesses data memory.
- dmem_ready  in  1  data memory completes the access this cycle.
- dmem_req  out  1  data-memory request.
- pc_en, IF_ID_en, ID_EX_en, EX_MEM_en, MEM_WB_en  out  1 each  register load enables.
- IF_ID_flush, ID_EX_flush  out  1 each  load a bubble (all control bits 0).
- MEM_WB_bubble  out  1  forces WB_regwrite=0 on the next MEM/WB capture.
- stall_cycles  out  CNT_W  saturating count of stall cycles.
- mem_err  out  1  sticky memory-timeout flag.

## Operation
- State register: RUN, MEM_WAIT, MEM_ERR. Reset state is RUN.
- Outputs are combinational from state and inputs. Only state, wait_cnt, stall_cycles and mem_err are registered.
- mem_op = MEM_memread | MEM_memwrite.
- dmem_req = (RUN & mem_op) | MEM_WAIT.
- **mem_stall** = (RUN & mem_op & !dmem_ready) | (MEM_WAIT & !dmem_ready).
  - All enables 0, flushes 0, MEM_WB_bubble=1.
  - MEM_WB_en stays 1, so a bubble enters WB.
- RUN transitions:
  - mem_op & !dmem_ready → MEM_WAIT, with wait_cnt ← 1.
  - Otherwise stay in RUN.
- MEM_WAIT transitions:
  - dmem_ready → RUN; stages advance this cycle.
  - !dmem_ready & wait_cnt==MEM_TIMEOUT → MEM_ERR.
  - Otherwise wait_cnt+1.
- MEM_ERR:
  - Terminal until reset.
  - All enables 0, flushes 0, dmem_req=0, mem_err=1.
- When not mem-stalled, priorities are:
  1. **Branch** (EX_branch_taken): all enables 1, IF_ID_flush=1, ID_EX_flush=1. A branch overrides load-use.
  2. **Load-use** (EX_memread & EX_writereg≠0 & (EX_writereg==ID_rs | EX_writereg==ID_rt)): pc_en=0, IF_ID_en=0, ID_EX_flush=1; EX_MEM_en and MEM_WB_en are 1.
  3. **Normal**: all enables 1, no flush, bubble 0.
- stall_cycles increments on every cycle with mem_stall or an active load-use stall. It saturates at all-ones and never wraps.
- Register $zero (index 0) never causes a hazard.

## Timing
- Zero-cycle decision latency: outputs respond to inputs in the same cycle.
- Memory access with dmem_ready in the first RUN cycle costs 0 stall cycles.
- Memory access with ready after N extra cycles costs N stall cycles and N bubbles into WB.
- Load-use costs exactly 1 stall cycle. The next cycle, EX holds the bubble and the hazard clears.
- Timeout: MEM_ERR is entered at the edge after MEM_TIMEOUT consecutive non-ready MEM_WAIT cycles.
- Simultaneous events:
  - mem_stall with branch or load-use: mem_stall wins; the branch/load-use is re-evaluated after release, because inputs are held by frozen stages.
  - dmem_ready on the same cycle wait_cnt==MEM_TIMEOUT: ready wins, go to RUN.
- Reset values while rst_n=0: state RUN, wait_cnt 0, stall_cycles 0, mem_err 0. All enables 0, flushes 0, bubble 0, dmem_req 0 (outputs gated by rst_n).
- Reset asserted mid-MEM_WAIT or in MEM_ERR returns to RUN immediately and asynchronously.

## Structure
- Shared package pipe_ctrl_pkg:
  - state enum {RUN, MEM_WAIT, MEM_ERR}
  - REG_ZERO = 5'd0
  - control-bundle bit positions, shared with the pipeline registers
- Sub-module load_use_detect: combinational hazard compare (ID_rs, ID_rt, EX_memread, EX_writereg → hazard).
- Top block holds the FSM, wait counter, stall counter and output priority mux.

## Test plan
- **Load-use**: EX_memread=1, EX_writereg=5, ID_rs=5 → one cycle with pc_en=0, IF_ID_en=0, ID_EX_flush=1; stall_cycles 0→1. Repeat with EX_writereg=0, ID_rs=0 → no stall.
- **Branch vs load-use**: EX_branch_taken=1 together with a load-use match → all enables 1, IF_ID_flush=ID_EX_flush=1, stall_cycles unchanged.
- **Slow memory**: MEM_memread=1, dmem_ready low for 3 cycles then high.
  - dmem_req high 4 cycles.
  - 3 cycles of all enables 0 except MEM_WB_en, with MEM_WB_bubble=1.
  - Release on cycle 4; stall_cycles=3.
- **Timeout**: MEM_TIMEOUT=4, dmem_ready held 0 → mem_err=1 after 4 MEM_WAIT cycles; all enables 0. A late dmem_ready is ignored. Pulsing rst_n low restores RUN with mem_err=0.
- **Saturation and async reset**:
  - CNT_W=4 with 20 load-use stalls → stall_cycles=15.
  - rst_n dropped mid-MEM_WAIT between clock edges → outputs zero immediately; after release, state is RUN.
